ale_core_scheduler: RTL and testbench
=====================================

Name: ale_core_scheduler

Overview:
Sequences a bank of NUM_CORES AleMiner cores working on one job. On a start pulse it hands each core a disjoint nonce partition of a shared base nonce, one core per cycle. It collects found nonces from all cores through per-core 1-deep holding slots and a round-robin arbiter into a single valid/ready result stream. It also aggregates hash counters and reports job completion.

Parameters:
NUM_CORES, 4, number of miner cores scheduled (2..16)
NONCE_W, 192, nonce width (6 x 32 bit words, word 0 = LSW)
PART_SHIFT, 160, partition stride exponent; core i base = BaseNonce_I + i*2^PART_SHIFT
STOP_ON_FIND, 1, 1 = abort all cores after first accepted result

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
Start_I  in  1  job start pulse, sampled in IDLE only
Stop_I  in  1  host abort pulse
BaseNonce_I  in  NONCE_W  job base nonce, sampled on accepted Start_I
CoreLoad_O  out  NUM_CORES  one-hot core start/load strobe
CoreNonce_O  out  NONCE_W  partition start nonce, valid with CoreLoad_O
CoreAbort_O  out  1  one-cycle abort pulse to all cores
CoreFound_I  in  NUM_CORES  per-core valid-nonce pulse
CoreNonce_I  in  NUM_CORES*NONCE_W  per-core found nonce, valid with CoreFound_I[i]
CoreDone_I  in  NUM_CORES  per-core range-exhausted level (Irq)
CoreHashCnt_I  in  NUM_CORES*32  per-core hash counters
ResVld_O  out  1  result valid
ResRdy_I  in  1  result accept
ResNonce_O  out  NONCE_W  result nonce
ResCore_O  out  $clog2(NUM_CORES)  originating core index
TotalHash_O  out  32+$clog2(NUM_CORES)  registered sum of CoreHashCnt_I
Busy_O  out  1  state != IDLE
Done_O  out  1  one-cycle job-complete pulse
Lost_O  out  1  sticky: a find was dropped (slot full); cleared on next accepted Start_I

Behaviour:
- Reset: state IDLE; all outputs 0, slots empty, round-robin pointer 0.
- IDLE: Start_I=1 -> latch BaseNonce_I, clear Lost_O, clear slots, go DISPATCH with idx=0. Start_I is ignored in all other states.
- DISPATCH: each cycle, CoreLoad_O = 1<<idx and CoreNonce_O = base + idx*2^PART_SHIFT. The add is modulo 2^NONCE_W, so carry out of the MSB is discarded. Core 0 loads on the cycle after Start_I; core N-1 loads N cycles after Start_I. After idx=N-1, go RUN.
- RUN: when all CoreDone_I bits are high and no slot is pending and ResVld_O=0, go IDLE and pulse Done_O.
- STOP: Stop_I in DISPATCH or RUN -> pulse CoreAbort_O next cycle, then go DRAIN; remaining cores are not loaded. STOP_ON_FIND=1 with a result handshake (ResVld_O&ResRdy_I) in RUN does the same.
- DRAIN: find pulses are still captured. When slots are empty and ResVld_O=0, go IDLE and pulse Done_O.
- Slots: CoreFound_I[i] with slot i empty -> capture the nonce, set pending. If slot i is already pending, drop the new find and set Lost_O. A find on the cycle the slot is granted is captured (the slot frees and refills in the same cycle). Finds in IDLE are ignored.
- Arbiter: when the output register is empty, or is being accepted this cycle, grant the first pending slot at or after the pointer. The granted data reaches ResNonce_O/ResCore_O with ResVld_O=1 the next cycle, so find-to-ResVld latency is 2 cycles. After a grant the pointer becomes grant+1 mod N. ResVld_O holds with stable data until ResRdy_I.
- TotalHash_O: registered sum of all counters, updated every cycle, 1-cycle latency, no saturation because the width covers the maximum sum.
- Start_I and Stop_I in the same IDLE cycle: Start wins and Stop is ignored.

Decomposition:
- Package ale_sched_pkg: state enum (IDLE, DISPATCH, RUN, DRAIN), NONCE_W, nonce_t typedef.
- Sub-module ale_rr_arbiter: parameterised NUM_CORES round-robin grant with pointer.

Test Plan:
- Reset mid-DISPATCH at core 2 -> all outputs 0 within the reset assertion; no further CoreLoad_O after release until a new Start_I.
- N=4, BaseNonce_I=0x00010203_..._14151617 (words 5..0), Start_I -> CoreLoad_O = 0001, 0010, 0100, 1000 on cycles 1-4. CoreNonce_O word 5 = 0x00010203, 0x00010204, 0x00010205, 0x00010206; other words unchanged.
- Base word 5 = 0xFFFFFFFF -> core 1 word 5 = 0x00000000, carry discarded.
- Finds on cores 1 and 3 in the same cycle, ResRdy_I=1 -> results core 1 then core 3 on consecutive cycles. A repeat of the same finds -> order 3 then 1 only if the pointer has advanced past 1.
- ResRdy_I=0, core 2 finds twice -> first find held in ResVld_O, second find held in the slot. A third find -> Lost_O=1, ResVld_O data stable.
- STOP_ON_FIND=1, first result accepted -> CoreAbort_O pulse, DRAIN, Done_O pulse. All CoreDone_I high in RUN with nothing pending -> Done_O one cycle later, Busy_O=0.

Source files
------------

// File: rtl/ale_core_scheduler_pkg.sv
// Shared types for the AleMiner core scheduler: FSM states and the default nonce width.
package ale_sched_pkg;

    localparam int NONCE_W = 192;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/ale_core_scheduler_if.sv
// Result stream of the scheduler: one found nonce plus its core index, valid/ready handshake.
interface ale_core_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 192
);
    localparam int CORE_W = $clog2(NUM_CORES);

    logic               ResVld_O;
    logic               ResRdy_I;
    logic [NONCE_W-1:0] ResNonce_O;
    logic [CORE_W-1:0]  ResCore_O;

    modport master (output ResVld_O, ResNonce_O, ResCore_O, input ResRdy_I);
    modport slave  (input ResVld_O, ResNonce_O, ResCore_O, output ResRdy_I);

endinterface

// File: rtl/ale_core_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer; the pointer
// moves to grant+1 (mod NUM_CORES) whenever a grant is taken.
module ale_rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         req_i,
    input  logic                         en_i,
    output logic                         gnt_vld_o,
    output logic [$clog2(NUM_CORES)-1:0] gnt_idx_o
);
    localparam int IDX_W = $clog2(NUM_CORES);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    int               pos;

    // NOTE: every output and temporary gets a default first, so no path leaves a latch.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_CORES) pos = pos - NUM_CORES;
            cand = IDX_W'(pos);
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && gnt_vld_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ale_core_scheduler.sv
// Job sequencer for a bank of AleMiner cores: partitioned dispatch, per-core 1-deep find
// slots merged round-robin into one result stream, hash aggregation and completion.
module ale_core_scheduler #(
    parameter int NUM_CORES    = 4,
    parameter int NONCE_W      = ale_sched_pkg::NONCE_W,
    parameter int PART_SHIFT   = 160,
    parameter bit STOP_ON_FIND = 1'b1
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic                              Start_I,
    input  logic                              Stop_I,
    input  logic [NONCE_W-1:0]                BaseNonce_I,
    output logic [NUM_CORES-1:0]              CoreLoad_O,
    output logic [NONCE_W-1:0]                CoreNonce_O,
    output logic                              CoreAbort_O,
    input  logic [NUM_CORES-1:0]              CoreFound_I,
    input  logic [NUM_CORES*NONCE_W-1:0]      CoreNonce_I,
    input  logic [NUM_CORES-1:0]              CoreDone_I,
    input  logic [NUM_CORES*32-1:0]           CoreHashCnt_I,
    ale_core_scheduler_if.master              res_if,
    output logic [32+$clog2(NUM_CORES)-1:0]   TotalHash_O,
    output logic                              Busy_O,
    output logic                              Done_O,
    output logic                              Lost_O
);
    import ale_sched_pkg::*;

    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam int CNT_W  = IDX_W + 1;
    localparam int HASH_W = 32 + IDX_W;

    state_e               state_q;
    logic [CNT_W-1:0]     idx_q;
    logic [NONCE_W-1:0]   base_q;
    logic [NUM_CORES-1:0] load_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic                 abort_q;
    logic                 done_q;
    logic                 busy_q;

    logic [NUM_CORES-1:0] pend_q;
    logic [NONCE_W-1:0]   slot_q [NUM_CORES];
    logic                 lost_q;

    logic                 res_vld_q;
    logic [NONCE_W-1:0]   res_nonce_q;
    logic [IDX_W-1:0]     res_core_q;

    logic [HASH_W-1:0]    hash_d;
    logic [HASH_W-1:0]    hash_q;

    logic                 gnt_vld;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 out_free;
    logic                 grant_take;
    logic [NUM_CORES-1:0] take_vec;
    logic [NUM_CORES-1:0] capture;
    logic                 accept;
    logic                 quiet;
    logic [NONCE_W-1:0]   part_nonce;

    assign out_free   = !res_vld_q || res_if.ResRdy_I;
    assign grant_take = gnt_vld && out_free;
    assign take_vec   = grant_take ? (NUM_CORES'(1) << gnt_idx) : '0;
    assign accept     = res_vld_q && res_if.ResRdy_I;
    assign quiet      = !(|pend_q) && !res_vld_q;
    // Partition base wraps modulo 2^NONCE_W; the carry out of the MSB is dropped.
    assign part_nonce = base_q + (NONCE_W'(idx_q) << PART_SHIFT);
    assign capture    = (state_q == IDLE) ? '0 : (CoreFound_I & (~pend_q | take_vec));

    ale_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .req_i     (pend_q),
        .en_i      (out_free),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            load_q  <= '0;
            nonce_q <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            load_q  <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start_I) begin
                        base_q  <= BaseNonce_I;
                        load_q  <= NUM_CORES'(1);
                        nonce_q <= BaseNonce_I;
                        idx_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (Stop_I) begin
                        abort_q <= 1'b1;
                        state_q <= DRAIN;
                    end else if (idx_q == CNT_W'(NUM_CORES)) begin
                        state_q <= RUN;
                    end else begin
                        load_q  <= NUM_CORES'(1) << idx_q;
                        nonce_q <= part_nonce;
                        idx_q   <= idx_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (Stop_I || (STOP_ON_FIND && accept)) begin
                        abort_q <= 1'b1;
                        state_q <= DRAIN;
                    end else if ((&CoreDone_I) && quiet) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (quiet) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A slot refills in the same cycle it is granted; a find into a still-full slot is lost.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_q <= '0;
            lost_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (Start_I) begin
                pend_q <= '0;
                lost_q <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (capture[i])          pend_q[i] <= 1'b1;
                else if (take_vec[i])    pend_q[i] <= 1'b0;
                if (CoreFound_I[i] && !capture[i]) lost_q <= 1'b1;
            end
        end
    end

    // NOTE: slot payloads are qualified by pend_q, so they carry no reset.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) slot_q[i] <= CoreNonce_I[i*NONCE_W +: NONCE_W];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            res_vld_q   <= 1'b0;
            res_nonce_q <= '0;
            res_core_q  <= '0;
        end else if (grant_take) begin
            res_vld_q   <= 1'b1;
            res_nonce_q <= slot_q[gnt_idx];
            res_core_q  <= gnt_idx;
        end else if (res_if.ResRdy_I) begin
            res_vld_q   <= 1'b0;
        end
    end

    always_comb begin
        hash_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hash_d = hash_d + HASH_W'(CoreHashCnt_I[i*32 +: 32]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) hash_q <= '0;
        else        hash_q <= hash_d;
    end

    assign CoreLoad_O        = load_q;
    assign CoreNonce_O       = nonce_q;
    assign CoreAbort_O       = abort_q;
    assign Busy_O            = busy_q;
    assign Done_O            = done_q;
    assign Lost_O            = lost_q;
    assign TotalHash_O       = hash_q;
    assign res_if.ResVld_O   = res_vld_q;
    assign res_if.ResNonce_O = res_nonce_q;
    assign res_if.ResCore_O  = res_core_q;

endmodule

// File: tb/tb_ale_core_scheduler.sv
// Self-checking bench for ale_core_scheduler: directed scenarios plus randomized jobs,
// hash sums and finds checked against expectations computed from the scheduling rules.
module tb_ale_core_scheduler;

    localparam int N  = 4;
    localparam int NW = 192;
    localparam int HW = 34;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b1;
    logic            Start_I = 1'b0;
    logic            Stop_I = 1'b0;
    logic [NW-1:0]   BaseNonce_I = '0;
    logic [N-1:0]    CoreLoad_O;
    logic [NW-1:0]   CoreNonce_O;
    logic            CoreAbort_O;
    logic [N-1:0]    CoreFound_I = '0;
    logic [N*NW-1:0] CoreNonce_I = '0;
    logic [N-1:0]    CoreDone_I = '0;
    logic [N*32-1:0] CoreHashCnt_I = '0;
    logic [HW-1:0]   TotalHash_O;
    logic            Busy_O;
    logic            Done_O;
    logic            Lost_O;

    int n_cmp = 0;
    int n_err = 0;

    int            got_core[$];
    logic [NW-1:0] got_nonce[$];
    logic [NW-1:0] core_val[N];

    ale_core_scheduler_if #(.NUM_CORES(N), .NONCE_W(NW)) res_if();

    ale_core_scheduler #(
        .NUM_CORES(N), .NONCE_W(NW), .PART_SHIFT(160), .STOP_ON_FIND(1'b1)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start_I(Start_I), .Stop_I(Stop_I),
        .BaseNonce_I(BaseNonce_I), .CoreLoad_O(CoreLoad_O), .CoreNonce_O(CoreNonce_O),
        .CoreAbort_O(CoreAbort_O), .CoreFound_I(CoreFound_I), .CoreNonce_I(CoreNonce_I),
        .CoreDone_I(CoreDone_I), .CoreHashCnt_I(CoreHashCnt_I), .res_if(res_if.master),
        .TotalHash_O(TotalHash_O), .Busy_O(Busy_O), .Done_O(Done_O), .Lost_O(Lost_O)
    );

    always #5 Clk = ~Clk;

    // Every cycle with valid and ready high is one accepted result.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && res_if.ResVld_O === 1'b1 && res_if.ResRdy_I === 1'b1) begin
            got_core.push_back(int'(res_if.ResCore_O));
            got_nonce.push_back(res_if.ResNonce_O);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NW-1:0] rand_nonce();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        Rst_n = 1'b0;
        Start_I = 1'b0;
        Stop_I = 1'b0;
        CoreFound_I = '0;
        CoreDone_I = '0;
        CoreHashCnt_I = '0;
        res_if.ResRdy_I = 1'b0;
        #2;
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic start_job(input logic [NW-1:0] base);
        BaseNonce_I = base;
        Start_I = 1'b1;
        tick();
        Start_I = 1'b0;
        repeat (N) tick();
    endtask

    task automatic wait_done(input string name);
        int  cyc = 0;
        bit  seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (Done_O === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done: Done_O never pulsed in %0d cycles (want 1)", name, cyc);
        end else begin
            n_cmp++;
            if (Busy_O !== 1'b0) begin
                n_err++;
                $display("FAIL %s_busy: Busy_O=%b with Done_O, want 0", name, Busy_O);
            end
        end
    endtask

    task automatic end_job(input string name);
        CoreDone_I = '1;
        wait_done(name);
        CoreDone_I = '0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        #1 Rst_n = 1'b0;
        CoreHashCnt_I = {N{32'h1234_5678}};
        #10;
        n_cmp++;
        if ({CoreLoad_O, CoreAbort_O, Busy_O, Done_O, Lost_O, res_if.ResVld_O} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {CoreLoad_O, CoreAbort_O, Busy_O, Done_O, Lost_O, res_if.ResVld_O});
        end
        n_cmp++;
        if ({CoreNonce_O, res_if.ResNonce_O, res_if.ResCore_O, TotalHash_O} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got nonce %h res %h hash %h want 0",
                     CoreNonce_O, res_if.ResNonce_O, TotalHash_O);
        end
        CoreHashCnt_I = '0;
        @(posedge Clk);
        #3 Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dispatch(input logic [NW-1:0] base, input string name);
        logic [NW-1:0] exp_n;
        BaseNonce_I = base;
        Start_I = 1'b1;
        tick();
        Start_I = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_n = base + (NW'(i) << 160);
            n_cmp++;
            if (CoreLoad_O !== N'(1 << i) || Busy_O !== 1'b1) begin
                n_err++;
                $display("FAIL %s_load%0d: got load %b busy %b want %b busy 1",
                         name, i, CoreLoad_O, Busy_O, N'(1 << i));
            end
            n_cmp++;
            if (CoreNonce_O !== exp_n) begin
                n_err++;
                $display("FAIL %s_nonce%0d: got %h want %h", name, i, CoreNonce_O, exp_n);
            end
            tick();
        end
        n_cmp++;
        if (CoreLoad_O !== '0) begin
            n_err++;
            $display("FAIL %s_load_end: got %b want 0", name, CoreLoad_O);
        end
    endtask

    task automatic test_dispatch_all();
        logic [NW-1:0] b;
        do_reset();
        b = {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 32'h10111213, 32'h14151617};
        test_dispatch(b, "disp_fixed");
        CoreDone_I = '1;
        tick();
        n_cmp++;
        if (Done_O !== 1'b1 || Busy_O !== 1'b0) begin
            n_err++;
            $display("FAIL run_done: got done %b busy %b want 1 0", Done_O, Busy_O);
        end
        tick();
        n_cmp++;
        if (Done_O !== 1'b0) begin
            n_err++;
            $display("FAIL run_done_pulse: got %b want 0", Done_O);
        end
        CoreDone_I = '0;
        b = rand_nonce();
        b[191:160] = 32'hFFFF_FFFF;
        test_dispatch(b, "disp_carry");
        end_job("disp_carry");
        for (int r = 0; r < 2; r++) begin
            test_dispatch(rand_nonce(), "disp_rand");
            end_job("disp_rand");
        end
    endtask

    task automatic run_arb(input logic [N-1:0] finds, input int e0, input int e1, input string name);
        int want;
        want = (e1 < 0) ? 1 : 2;
        start_job(rand_nonce());
        res_if.ResRdy_I = 1'b1;
        for (int i = 0; i < N; i++) begin
            core_val[i] = rand_nonce();
            CoreNonce_I[i*NW +: NW] = core_val[i];
        end
        got_core.delete();
        got_nonce.delete();
        CoreFound_I = finds;
        tick();
        CoreFound_I = '0;
        n_cmp++;
        if (res_if.ResVld_O !== 1'b0) begin
            n_err++;
            $display("FAIL %s_lat1: ResVld_O=%b one cycle after find, want 0", name, res_if.ResVld_O);
        end
        tick();
        n_cmp++;
        if (res_if.ResVld_O !== 1'b1) begin
            n_err++;
            $display("FAIL %s_lat2: ResVld_O=%b two cycles after find, want 1", name, res_if.ResVld_O);
        end
        wait_done(name);
        n_cmp++;
        if (got_core.size() != want) begin
            n_err++;
            $display("FAIL %s_count: got %0d results want %0d", name, got_core.size(), want);
        end else begin
            n_cmp++;
            if (got_core[0] != e0 || got_nonce[0] !== core_val[e0]) begin
                n_err++;
                $display("FAIL %s_first: got core %0d nonce %h want core %0d nonce %h",
                         name, got_core[0], got_nonce[0], e0, core_val[e0]);
            end
            if (want == 2) begin
                n_cmp++;
                if (got_core[1] != e1 || got_nonce[1] !== core_val[e1]) begin
                    n_err++;
                    $display("FAIL %s_second: got core %0d nonce %h want core %0d nonce %h",
                             name, got_core[1], got_nonce[1], e1, core_val[e1]);
                end
            end
        end
        res_if.ResRdy_I = 1'b0;
    endtask

    task automatic test_arbiter();
        do_reset();
        run_arb(4'b1010, 1, 3, "arb_ptr0");
        run_arb(4'b1010, 1, 3, "arb_ptr0_again");
        run_arb(4'b0010, 1, -1, "arb_single");
        run_arb(4'b1010, 3, 1, "arb_ptr2");
    endtask

    task automatic test_backpressure();
        logic [NW-1:0] n1, n2, n3;
        do_reset();
        start_job(rand_nonce());
        n1 = rand_nonce(); n2 = rand_nonce(); n3 = rand_nonce();
        got_core.delete();
        got_nonce.delete();
        CoreNonce_I[2*NW +: NW] = n1;
        CoreFound_I = 4'b0100;
        tick();
        CoreFound_I = '0;
        tick();
        n_cmp++;
        if (res_if.ResVld_O !== 1'b1 || res_if.ResNonce_O !== n1 || res_if.ResCore_O !== 2'd2) begin
            n_err++;
            $display("FAIL bp_first: got vld %b core %0d nonce %h want 1 2 %h",
                     res_if.ResVld_O, res_if.ResCore_O, res_if.ResNonce_O, n1);
        end
        CoreNonce_I[2*NW +: NW] = n2;
        CoreFound_I = 4'b0100;
        tick();
        CoreFound_I = '0;
        tick();
        n_cmp++;
        if (res_if.ResNonce_O !== n1 || Lost_O !== 1'b0) begin
            n_err++;
            $display("FAIL bp_held: got nonce %h lost %b want %h 0", res_if.ResNonce_O, Lost_O, n1);
        end
        CoreNonce_I[2*NW +: NW] = n3;
        CoreFound_I = 4'b0100;
        tick();
        CoreFound_I = '0;
        n_cmp++;
        if (Lost_O !== 1'b1 || res_if.ResNonce_O !== n1 || res_if.ResVld_O !== 1'b1) begin
            n_err++;
            $display("FAIL bp_lost: got lost %b vld %b nonce %h want 1 1 %h",
                     Lost_O, res_if.ResVld_O, res_if.ResNonce_O, n1);
        end
        res_if.ResRdy_I = 1'b1;
        tick();
        n_cmp++;
        if (res_if.ResVld_O !== 1'b1 || res_if.ResNonce_O !== n2 || CoreAbort_O !== 1'b1) begin
            n_err++;
            $display("FAIL bp_refill: got vld %b nonce %h abort %b want 1 %h 1",
                     res_if.ResVld_O, res_if.ResNonce_O, CoreAbort_O, n2);
        end
        wait_done("bp");
        n_cmp++;
        if (got_nonce.size() != 2 || Lost_O !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: got %0d results lost %b want 2 results lost 1",
                     got_nonce.size(), Lost_O);
        end
        res_if.ResRdy_I = 1'b0;
        BaseNonce_I = rand_nonce();
        Start_I = 1'b1;
        tick();
        Start_I = 1'b0;
        n_cmp++;
        if (Lost_O !== 1'b0) begin
            n_err++;
            $display("FAIL bp_lost_clear: got %b want 0", Lost_O);
        end
        repeat (N) tick();
        end_job("bp_next");
    endtask

    task automatic test_stop_on_find();
        do_reset();
        start_job(rand_nonce());
        res_if.ResRdy_I = 1'b1;
        CoreNonce_I[0 +: NW] = rand_nonce();
        CoreFound_I = 4'b0001;
        tick();
        CoreFound_I = '0;
        tick();
        tick();
        n_cmp++;
        if (CoreAbort_O !== 1'b1 || Busy_O !== 1'b1 || res_if.ResVld_O !== 1'b0) begin
            n_err++;
            $display("FAIL sof_abort: got abort %b busy %b vld %b want 1 1 0",
                     CoreAbort_O, Busy_O, res_if.ResVld_O);
        end
        tick();
        n_cmp++;
        if (CoreAbort_O !== 1'b0 || Done_O !== 1'b1 || Busy_O !== 1'b0) begin
            n_err++;
            $display("FAIL sof_done: got abort %b done %b busy %b want 0 1 0",
                     CoreAbort_O, Done_O, Busy_O);
        end
        res_if.ResRdy_I = 1'b0;
    endtask

    task automatic test_host_stop();
        int stray = 0;
        do_reset();
        BaseNonce_I = rand_nonce();
        Start_I = 1'b1;
        Stop_I = 1'b1;
        tick();
        Start_I = 1'b0;
        Stop_I = 1'b0;
        n_cmp++;
        if (CoreLoad_O !== 4'b0001 || CoreAbort_O !== 1'b0) begin
            n_err++;
            $display("FAIL stop_start_wins: got load %b abort %b want 0001 0", CoreLoad_O, CoreAbort_O);
        end
        tick();
        Stop_I = 1'b1;
        tick();
        Stop_I = 1'b0;
        n_cmp++;
        if (CoreAbort_O !== 1'b1 || CoreLoad_O !== '0) begin
            n_err++;
            $display("FAIL stop_abort: got abort %b load %b want 1 0000", CoreAbort_O, CoreLoad_O);
        end
        tick();
        n_cmp++;
        if (Done_O !== 1'b1 || Busy_O !== 1'b0) begin
            n_err++;
            $display("FAIL stop_done: got done %b busy %b want 1 0", Done_O, Busy_O);
        end
        repeat (4) begin
            tick();
            if (CoreLoad_O !== '0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL stop_no_more_loads: got %0d load cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid_dispatch();
        int stray = 0;
        do_reset();
        CoreHashCnt_I = {32'd7, 32'd5, 32'd3, 32'd1};
        BaseNonce_I = rand_nonce();
        Start_I = 1'b1;
        tick();
        Start_I = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (CoreLoad_O !== 4'b0100) begin
            n_err++;
            $display("FAIL rst_mid_pre: got load %b want 0100", CoreLoad_O);
        end
        #2 Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({CoreLoad_O, CoreAbort_O, Busy_O, Done_O, Lost_O, res_if.ResVld_O} !== '0 ||
            CoreNonce_O !== '0 || TotalHash_O !== '0) begin
            n_err++;
            $display("FAIL rst_mid_zero: got load %b busy %b nonce %h hash %h want all 0",
                     CoreLoad_O, Busy_O, CoreNonce_O, TotalHash_O);
        end
        @(posedge Clk);
        #3 Rst_n = 1'b1;
        CoreHashCnt_I = '0;
        repeat (6) begin
            tick();
            if (CoreLoad_O !== '0 || Busy_O !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: got %0d active cycles after release want 0", stray);
        end
    endtask

    task automatic test_hash();
        longint unsigned s;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            if (it == 0) CoreHashCnt_I = '1;
            else for (int i = 0; i < N; i++) CoreHashCnt_I[i*32 +: 32] = $urandom;
            s = 0;
            for (int i = 0; i < N; i++) s = s + longint'(CoreHashCnt_I[i*32 +: 32]);
            tick();
            n_cmp++;
            if (TotalHash_O !== HW'(s)) begin
                n_err++;
                $display("FAIL hash%0d: got %h want %h", it, TotalHash_O, HW'(s));
            end
        end
        CoreHashCnt_I = '0;
    endtask

    task automatic test_random_finds();
        int t[N];
        int hits;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            start_job(rand_nonce());
            res_if.ResRdy_I = 1'b0;
            for (int i = 0; i < N; i++) begin
                core_val[i] = rand_nonce();
                CoreNonce_I[i*NW +: NW] = core_val[i];
                t[i] = $urandom_range(0, 5);
            end
            got_core.delete();
            got_nonce.delete();
            for (int c = 0; c < 6; c++) begin
                for (int i = 0; i < N; i++) CoreFound_I[i] = (t[i] == c);
                tick();
            end
            CoreFound_I = '0;
            tick();
            n_cmp++;
            if (Lost_O !== 1'b0 || res_if.ResVld_O !== 1'b1) begin
                n_err++;
                $display("FAIL rnd%0d_hold: got lost %b vld %b want 0 1", r, Lost_O, res_if.ResVld_O);
            end
            res_if.ResRdy_I = 1'b1;
            wait_done("rnd");
            res_if.ResRdy_I = 1'b0;
            n_cmp++;
            if (got_core.size() != N) begin
                n_err++;
                $display("FAIL rnd%0d_count: got %0d results want %0d", r, got_core.size(), N);
            end
            for (int i = 0; i < N; i++) begin
                hits = 0;
                foreach (got_core[k]) if (got_core[k] == i && got_nonce[k] === core_val[i]) hits++;
                n_cmp++;
                if (hits != 1) begin
                    n_err++;
                    $display("FAIL rnd%0d_core%0d: got %0d matching results want 1", r, i, hits);
                end
            end
        end
    endtask

    initial begin
        res_if.ResRdy_I = 1'b0;
        test_reset();
        test_dispatch_all();
        test_arbiter();
        test_backpressure();
        test_stop_on_find();
        test_host_stop();
        test_reset_mid_dispatch();
        test_hash();
        test_random_finds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
